// File: rtl/pim_seq_pkg.sv
// Shared definitions for the PIM immediate sequencer: the FSM state type and
// default widths that tie the sequencer to its sibling shift register.
package pim_seq_pkg;

  localparam int PIM_IMM_N  = 25;
  localparam int PIM_COL_AW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/imm_bit_sequencer.sv
// Steps the bit-serial immediate shift register one bit per accepted crossbar
// operation, presenting each bit LSB first with its target column.
module imm_bit_sequencer
  import pim_seq_pkg::*;
#(
  parameter int N  = PIM_IMM_N,
  parameter int CW = 5,
  parameter int AW = PIM_COL_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_valid,
  output logic          start_ready,
  input  logic [CW-1:0] start_len,
  input  logic [AW-1:0] start_col,
  output logic          pim_load,
  output logic          update_load,
  input  logic          imm_bit,
  input  logic          abort,
  output logic          op_valid,
  output logic          op_bit,
  output logic [AW-1:0] op_col,
  input  logic          op_ready,
  output logic          busy,
  output logic          done
);

  localparam logic [CW-1:0] N_MAX = CW'(N);

  seq_state_t    state;
  logic [CW-1:0] idx;
  logic [CW-1:0] len;
  logic [AW-1:0] base;
  logic [CW-1:0] len_clamped;
  logic          accept;
  logic          fire;
  logic          in_run;

  // start_ready is gated by rst so that nothing, not even a load strobe, leaks out during reset
  assign in_run      = (state == RUN);
  assign start_ready = (state == IDLE) && !rst;
  assign accept      = start_valid && start_ready;
  assign fire        = in_run && op_ready && !abort;
  assign len_clamped = (start_len > N_MAX) ? N_MAX : start_len;

  assign pim_load    = accept;
  assign update_load = fire;
  assign op_valid    = in_run;
  assign op_bit      = in_run && imm_bit;
  assign op_col      = in_run ? (base + AW'(idx)) : '0;
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      len   <= '0;
      base  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            len   <= len_clamped;
            base  <= start_col;
            idx   <= '0;
            state <= (len_clamped == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          // abort wins over op_ready; a stalled cycle leaves idx and the register untouched
          if (abort) begin
            state <= IDLE;
          end else if (fire) begin
            idx <= idx + CW'(1);
            if (idx == len - CW'(1)) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
